// File: rtl/multi_alarm_clock.sv
// Multi-slot alarm clock: 24 h time of day driven by a tick prescaler,
// NUM_ALARMS programmable hh:mm alarm slots, ring/snooze/auto-silence FSM.
`timescale 1ns/1ps
module multi_alarm_clock #(
  parameter  int NUM_ALARMS    = 4,
  parameter  int TICKS_PER_SEC = 2,
  parameter  int SNOOZE_MIN    = 5,
  parameter  int RING_SECS     = 60,
  localparam int SEL_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  time_set,
  input  logic                  alarm_set,
  input  logic                  set_hrs1_min0,
  input  logic                  inc,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  alarm_ack,
  output logic [7:0]            sec,
  output logic [7:0]            min,
  output logic [7:0]            hrs,
  output logic [7:0]            min_alrm,
  output logic [7:0]            hrs_alrm,
  output logic                  alrm,
  output logic [SEL_W-1:0]      ring_id,
  output logic                  snoozed
);

  localparam int PW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW    = $clog2(RING_SECS + 1);
  // Slot storage is padded to the full alarm_sel range so any select value
  // addresses a real entry; only the first NUM_ALARMS slots can ring.
  localparam int SLOTS = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc;
  logic [7:0]      alm_min [SLOTS];
  logic [7:0]      alm_hrs [SLOTS];
  logic [SLOTS-1:0] en_pad;
  logic [7:0]      tgt_min, tgt_hrs;
  logic [RW-1:0]   ring_cnt;
  logic            sec_wrap, min_carry, carry_q, time_set_q;
  logic            ts_rise, match_ok, hit;
  logic [SEL_W-1:0] hit_id;
  logic            load_ring, clr_cnt, inc_cnt, load_tgt;
  logic [15:0]     snz;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] top);
    return (v == top) ? 8'd0 : v + 8'd1;
  endfunction

  // Current hh:mm plus the snooze delay, wrapping past midnight.
  function automatic logic [15:0] snooze_target(input logic [7:0] h, input logic [7:0] m);
    logic [7:0] m_sum;
    logic [7:0] h_new;
    m_sum = m + 8'(SNOOZE_MIN);
    h_new = h;
    if (m_sum >= 8'd60) begin
      m_sum = m_sum - 8'd60;
      h_new = wrap_inc(h, 8'd23);
    end
    return {h_new, m_sum};
  endfunction

  assign sec_wrap  = tick & ~time_set & (presc == PW'(TICKS_PER_SEC - 1));
  assign min_carry = sec_wrap & (sec == 8'd59);
  assign ts_rise   = time_set & ~time_set_q;
  // A match is only considered in the cycle right after a run-mode minute
  // carry, so reset release and time_set edits can never fire an alarm.
  assign match_ok  = carry_q & ~time_set;
  assign en_pad    = SLOTS'(alarm_en);
  assign snz       = snooze_target(hrs, min);

  assign min_alrm  = alm_min[alarm_sel];
  assign hrs_alrm  = alm_hrs[alarm_sel];
  assign alrm      = (state == RINGING);
  assign snoozed   = (state == SNOOZED);

  // Timekeeping: prescaler and sec/min/hrs in run mode, direct edits in set-time mode.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      sec   <= '0;
      min   <= '0;
      hrs   <= '0;
    end else if (time_set) begin
      if (inc) begin
        if (set_hrs1_min0) hrs <= wrap_inc(hrs, 8'd23);
        else               min <= wrap_inc(min, 8'd59);
      end
    end else if (tick) begin
      if (sec_wrap) begin
        presc <= '0;
        sec   <= wrap_inc(sec, 8'd59);
        if (sec == 8'd59) begin
          min <= wrap_inc(min, 8'd59);
          if (min == 8'd59) hrs <= wrap_inc(hrs, 8'd23);
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Edge-detect helpers: minute-carry flag and time_set history.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      carry_q    <= 1'b0;
      time_set_q <= 1'b0;
    end else begin
      carry_q    <= min_carry;
      time_set_q <= time_set;
    end
  end

  // Alarm slot storage, edited only in set-alarm mode with set-time low.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        alm_min[i] <= '0;
        alm_hrs[i] <= '0;
      end
    end else if (alarm_set && !time_set && inc) begin
      if (set_hrs1_min0) alm_hrs[alarm_sel] <= wrap_inc(alm_hrs[alarm_sel], 8'd23);
      else               alm_min[alarm_sel] <= wrap_inc(alm_min[alarm_sel], 8'd59);
    end
  end

  // Lowest-numbered enabled slot whose hh:mm equals the current time.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (alarm_en[k] && alm_min[k] == min && alm_hrs[k] == hrs) begin
        hit    = 1'b1;
        hit_id = SEL_W'(k);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state and side-effect strobes; cancel conditions take priority.
  always_comb begin
    state_nxt = state;
    load_ring = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    load_tgt  = 1'b0;
    case (state)
      IDLE: begin
        if (match_ok && hit) begin
          state_nxt = RINGING;
          load_ring = 1'b1;
          clr_cnt   = 1'b1;
        end
      end
      RINGING: begin
        if (ts_rise || alarm_ack || !en_pad[ring_id]) begin
          state_nxt = IDLE;
        end else if (snooze) begin
          state_nxt = SNOOZED;
          load_tgt  = 1'b1;
        end else if (sec_wrap) begin
          if (ring_cnt == RW'(RING_SECS - 1)) state_nxt = IDLE;
          else                                inc_cnt   = 1'b1;
        end
      end
      SNOOZED: begin
        if (ts_rise || alarm_ack || !en_pad[ring_id]) begin
          state_nxt = IDLE;
        end else if (match_ok && min == tgt_min && hrs == tgt_hrs) begin
          state_nxt = RINGING;
          clr_cnt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ring bookkeeping: source slot, snooze target and elapsed ring seconds.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ring_id  <= '0;
      tgt_min  <= '0;
      tgt_hrs  <= '0;
      ring_cnt <= '0;
    end else begin
      if (load_ring) ring_id <= hit_id;
      if (load_tgt) begin
        tgt_hrs <= snz[15:8];
        tgt_min <= snz[7:0];
      end
      if (clr_cnt)      ring_cnt <= '0;
      else if (inc_cnt) ring_cnt <= ring_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: a table of single-cycle edit/tick
// vectors plus hand-written ring, snooze, reset and cancel sequences.
`timescale 1ns/1ps
module tb_multi_alarm_clock;

  logic       CLK = 1'b0;
  logic       reset_n, tick, time_set, alarm_set, set_hrs1_min0, inc;
  logic [1:0] alarm_sel;
  logic [3:0] alarm_en;
  logic       snooze, alarm_ack;
  logic [7:0] sec, min, hrs, min_alrm, hrs_alrm;
  logic       alrm, snoozed;
  logic [1:0] ring_id;

  int checks   = 0;
  int failures = 0;

  multi_alarm_clock dut (
    .CLK(CLK), .reset_n(reset_n), .tick(tick), .time_set(time_set),
    .alarm_set(alarm_set), .set_hrs1_min0(set_hrs1_min0), .inc(inc),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .snooze(snooze),
    .alarm_ack(alarm_ack), .sec(sec), .min(min), .hrs(hrs),
    .min_alrm(min_alrm), .hrs_alrm(hrs_alrm), .alrm(alrm),
    .ring_id(ring_id), .snoozed(snoozed)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ts, as, hsel, inc, tk;
    logic [1:0] sel;
    logic [7:0] e_sec, e_min, e_hrs, e_amin, e_ahrs;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick = 0; time_set = 0; alarm_set = 0; set_hrs1_min0 = 0; inc = 0;
    alarm_sel = 0; alarm_en = 0; snooze = 0; alarm_ack = 0;
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    @(negedge CLK);
    inc = 1'b0;
  endtask

  task automatic adjust_time(input int dh, input int dm);
    time_set = 1'b1;
    set_hrs1_min0 = 1'b1;
    repeat (dh) pulse_inc();
    set_hrs1_min0 = 1'b0;
    repeat (dm) pulse_inc();
    time_set = 1'b0;
    @(negedge CLK);
  endtask

  task automatic inc_alarm(input logic [1:0] k, input int dh, input int dm);
    alarm_sel = k;
    alarm_set = 1'b1;
    set_hrs1_min0 = 1'b1;
    repeat (dh) pulse_inc();
    set_hrs1_min0 = 1'b0;
    repeat (dm) pulse_inc();
    alarm_set = 1'b0;
    @(negedge CLK);
  endtask

  // n seconds = 2n tick pulses, each followed by an idle cycle.
  task automatic run_secs(input int n);
    for (int i = 0; i < 2 * n; i++) begin
      tick = 1'b1;
      @(negedge CLK);
      tick = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic one_pulse_ack_snooze(input logic a, input logic s);
    alarm_ack = a;
    snooze    = s;
    @(negedge CLK);
    alarm_ack = 1'b0;
    snooze    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            ts  as  hs  inc tk  sel   sec min hrs amin ahrs
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'd0, 8'd0,8'd0,8'd0,8'd0,8'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'd0, 8'd1,8'd0,8'd0,8'd0,8'd0};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,2'd0, 8'd1,8'd1,8'd0,8'd0,8'd0};
    vt[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,2'd0, 8'd1,8'd1,8'd0,8'd0,8'd0};
    vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,2'd0, 8'd1,8'd1,8'd0,8'd0,8'd0};
    vt[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,2'd0, 8'd1,8'd1,8'd1,8'd0,8'd0};
    vt[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,2'd2, 8'd1,8'd1,8'd1,8'd0,8'd1};
    vt[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'd2, 8'd1,8'd1,8'd1,8'd1,8'd1};
    vt[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,2'd2, 8'd1,8'd2,8'd1,8'd1,8'd1};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'd2, 8'd1,8'd2,8'd1,8'd1,8'd1};
    vt[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,2'd1, 8'd1,8'd2,8'd1,8'd0,8'd1};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd2, 8'd1,8'd2,8'd1,8'd1,8'd1};
    vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'd2, 8'd1,8'd2,8'd1,8'd1,8'd1};
    vt[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1,2'd2, 8'd2,8'd2,8'd1,8'd2,8'd1};

    // Reset state
    do_reset();
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_hrs", hrs, 0);
    check("rst_alrm", alrm, 0);
    check("rst_snoozed", snoozed, 0);
    check("rst_ring_id", ring_id, 0);
    check("rst_min_alrm", min_alrm, 0);

    // Table of single-cycle edits and ticks
    for (int i = 0; i < 14; i++) begin
      time_set = vt[i].ts; alarm_set = vt[i].as; set_hrs1_min0 = vt[i].hsel;
      inc = vt[i].inc; tick = vt[i].tk; alarm_sel = vt[i].sel;
      @(negedge CLK);
      time_set = 0; alarm_set = 0; inc = 0; tick = 0;
      check($sformatf("vec%0d_sec", i), sec, vt[i].e_sec);
      check($sformatf("vec%0d_min", i), min, vt[i].e_min);
      check($sformatf("vec%0d_hrs", i), hrs, vt[i].e_hrs);
      check($sformatf("vec%0d_amin", i), min_alrm, vt[i].e_amin);
      check($sformatf("vec%0d_ahrs", i), hrs_alrm, vt[i].e_ahrs);
    end

    // Midnight rollover
    do_reset();
    adjust_time(23, 59);
    run_secs(58);
    check("a_sec58", sec, 58);
    check("a_min59", min, 59);
    check("a_hrs23", hrs, 23);
    run_secs(2);
    check("a_mid_sec", sec, 0);
    check("a_mid_min", min, 0);
    check("a_mid_hrs", hrs, 0);
    run_secs(1);
    check("a_sec1", sec, 1);

    // Single alarm, one-cycle latency, auto-silence
    do_reset();
    inc_alarm(2'd2, 6, 30);
    alarm_en = 4'b0100;
    adjust_time(6, 29);
    run_secs(59);
    tick = 1; @(negedge CLK); tick = 0; @(negedge CLK);
    tick = 1; @(negedge CLK); tick = 0;
    check("b_at_min", min, 30);
    check("b_at_sec", sec, 0);
    check("b_alrm_not_yet", alrm, 0);
    @(negedge CLK);
    check("b_alrm_rise", alrm, 1);
    check("b_ring_id", ring_id, 2);
    run_secs(59);
    check("b_still_ring", alrm, 1);
    run_secs(1);
    check("b_silenced", alrm, 0);
    check("b_min31", min, 31);
    run_secs(1);
    check("b_stay_idle", alrm, 0);

    // Simultaneous matches, ack beats snooze
    do_reset();
    inc_alarm(2'd1, 7, 0);
    inc_alarm(2'd3, 7, 0);
    alarm_en = 4'b1010;
    adjust_time(6, 59);
    run_secs(60);
    check("c_alrm", alrm, 1);
    check("c_ring_id", ring_id, 1);
    one_pulse_ack_snooze(1'b1, 1'b1);
    check("c_ack_alrm", alrm, 0);
    check("c_ack_snoozed", snoozed, 0);
    run_secs(2);
    check("c_idle_alrm", alrm, 0);

    // Snooze across midnight
    do_reset();
    inc_alarm(2'd0, 23, 58);
    alarm_en = 4'b0001;
    adjust_time(23, 57);
    run_secs(60);
    check("d_ring", alrm, 1);
    check("d_ring_id", ring_id, 0);
    one_pulse_ack_snooze(1'b0, 1'b1);
    check("d_snoozed", snoozed, 1);
    check("d_snz_alrm", alrm, 0);
    run_secs(299);
    check("d_pre_min", min, 2);
    check("d_pre_snoozed", snoozed, 1);
    check("d_pre_alrm", alrm, 0);
    run_secs(1);
    check("d_re_min", min, 3);
    check("d_re_hrs", hrs, 0);
    check("d_re_alrm", alrm, 1);
    check("d_re_snoozed", snoozed, 0);
    check("d_re_id", ring_id, 0);
    one_pulse_ack_snooze(1'b1, 1'b0);
    check("d_ack_alrm", alrm, 0);
    check("d_ack_snoozed", snoozed, 0);

    // Asynchronous reset while ringing
    do_reset();
    inc_alarm(2'd0, 0, 1);
    alarm_en = 4'b0001;
    run_secs(60);
    check("e_ring", alrm, 1);
    #2 reset_n = 1'b0;
    #1;
    check("e_rst_alrm", alrm, 0);
    check("e_rst_min", min, 0);
    check("e_rst_sec", sec, 0);
    check("e_rst_amin", min_alrm, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    check("e_rel_alrm", alrm, 0);
    run_secs(2);
    check("e_no_ring", alrm, 0);

    // Disabled slot, time_set edit onto alarm time, alarm minute wrap
    do_reset();
    inc_alarm(2'd1, 0, 2);
    alarm_en = 4'b0000;
    run_secs(120);
    check("f_min2", min, 2);
    check("f_disabled", alrm, 0);
    inc_alarm(2'd1, 0, 1);
    alarm_en = 4'b0010;
    time_set = 1'b1; set_hrs1_min0 = 1'b0;
    pulse_inc();
    run_secs(2);
    check("f_ts_min", min, 3);
    check("f_ts_sec", sec, 0);
    check("f_ts_alrm", alrm, 0);
    time_set = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check("f_ts_rel_alrm", alrm, 0);
    alarm_sel = 2'd1; alarm_set = 1'b1; set_hrs1_min0 = 1'b1;
    pulse_inc();
    set_hrs1_min0 = 1'b0;
    repeat (56) pulse_inc();
    check("f_amin59", min_alrm, 59);
    check("f_ahrs_pre", hrs_alrm, 1);
    pulse_inc();
    check("f_amin_wrap", min_alrm, 0);
    check("f_ahrs_keep", hrs_alrm, 1);
    alarm_set = 1'b0;

    // Cancel by enable drop and by time_set rising
    do_reset();
    inc_alarm(2'd0, 0, 1);
    alarm_en = 4'b0001;
    run_secs(60);
    check("g_ring1", alrm, 1);
    alarm_en = 4'b0000;
    @(negedge CLK);
    check("g_en_drop", alrm, 0);
    inc_alarm(2'd0, 0, 1);
    alarm_en = 4'b0001;
    run_secs(60);
    check("g_ring2", alrm, 1);
    time_set = 1'b1;
    @(negedge CLK);
    check("g_ts_cancel", alrm, 0);
    time_set = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
